// File: rtl/stereo_mpx_mod.sv
// stereo_mpx_mod: three-stage FM stereo composite (MPX) modulator with pilot, clamp and sticky overflow
module stereo_mpx_mod #(
  parameter int OUT_WIDTH   = 10,
  parameter int AUDIO_WIDTH = 16,
  parameter int MPX_WIDTH   = 16,
  parameter int AUDIO_SHIFT = 2,
  parameter int PILOT_SHIFT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic                          audio_valid,
  input  logic signed [AUDIO_WIDTH-1:0] audio_l,
  input  logic signed [AUDIO_WIDTH-1:0] audio_r,
  input  logic signed [OUT_WIDTH-1:0]   fsin_i,
  input  logic signed [OUT_WIDTH-1:0]   fsin2x_i,
  input  logic                          stereo_en,
  input  logic                          pilot_en,
  input  logic                          overflow_clr,
  output logic signed [MPX_WIDTH-1:0]   mpx_o,
  output logic                          mpx_valid,
  output logic                          overflow
);
  localparam int AW1 = AUDIO_WIDTH + 1;
  localparam int PW  = AW1 + OUT_WIDTH;
  localparam int SW  = PW + MPX_WIDTH + 2;
  localparam int PS  = MPX_WIDTH - OUT_WIDTH - PILOT_SHIFT;
  localparam logic signed [SW-1:0] MAX = {{(SW-MPX_WIDTH+1){1'b0}}, {(MPX_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN = ~MAX;
  logic signed [AUDIO_WIDTH-1:0] r_l, r_r;
  logic signed [AW1-1:0]         r_m1, r_s1, r_m2;
  logic signed [OUT_WIDTH-1:0]   r_c1, r_p1, r_p2;
  logic signed [PW-1:0]          r_prod2;
  logic [1:0]                    r_fill;
  logic signed [SW-1:0]          w_sum;
  logic                          w_hi, w_lo;
  logic signed [MPX_WIDTH-1:0]   w_mpx;
  always_comb begin
    w_sum = (((SW'(r_m2) <<< (OUT_WIDTH-1)) + SW'(r_prod2)) >>> (OUT_WIDTH-1+AUDIO_SHIFT))
          + (SW'(r_p2) <<< PS);
    w_hi  = w_sum > MAX;
    w_lo  = w_sum < MIN;
    w_mpx = w_hi ? MAX[MPX_WIDTH-1:0] : w_lo ? MIN[MPX_WIDTH-1:0] : w_sum[MPX_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l       <= '0;
      r_r       <= '0;
      r_m1      <= '0;
      r_s1      <= '0;
      r_c1      <= '0;
      r_p1      <= '0;
      r_prod2   <= '0;
      r_m2      <= '0;
      r_p2      <= '0;
      r_fill    <= '0;
      mpx_o     <= '0;
      mpx_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (audio_valid) begin
        r_l <= audio_l;
        r_r <= audio_r;
      end
      mpx_valid <= clken && r_fill[1];
      if (clken) begin
        r_m1    <= AW1'(r_l) + AW1'(r_r);
        r_s1    <= AW1'(r_l) - AW1'(r_r);
        r_c1    <= stereo_en ? fsin2x_i : '0;
        r_p1    <= (stereo_en && pilot_en) ? fsin_i : '0;
        r_prod2 <= PW'(r_s1) * PW'(r_c1);
        r_m2    <= r_m1;
        r_p2    <= r_p1;
        mpx_o   <= w_mpx;
        r_fill  <= r_fill + {1'b0, ~&r_fill};
      end
      overflow <= (clken && (w_hi || w_lo)) || (overflow && !overflow_clr);
    end
  end
endmodule

// File: tb/tb_stereo_mpx_mod.sv
// tb_stereo_mpx_mod: scoreboard bench; default instance plus an AUDIO_SHIFT=0 instance for saturation
module tb_stereo_mpx_mod;
  logic clk = 0, reset_n = 0, clken = 0, audio_valid = 0;
  logic stereo_en = 0, pilot_en = 0, overflow_clr = 0;
  logic signed [15:0] audio_l = 0, audio_r = 0;
  logic signed [9:0]  fsin_i = 0, fsin2x_i = 0;
  logic signed [15:0] mpx_o, s_mpx;
  logic mpx_valid, overflow, s_valid, s_ovf;
  int checks = 0, errors = 0, fill = 0;
  typedef struct {bit cm; int em; bit cs; int es; bit eos;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  stereo_mpx_mod u_dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .audio_valid(audio_valid),
    .audio_l(audio_l), .audio_r(audio_r), .fsin_i(fsin_i), .fsin2x_i(fsin2x_i),
    .stereo_en(stereo_en), .pilot_en(pilot_en), .overflow_clr(overflow_clr),
    .mpx_o(mpx_o), .mpx_valid(mpx_valid), .overflow(overflow));
  stereo_mpx_mod #(.AUDIO_SHIFT(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .clken(clken), .audio_valid(audio_valid),
    .audio_l(audio_l), .audio_r(audio_r), .fsin_i(fsin_i), .fsin2x_i(fsin2x_i),
    .stereo_en(stereo_en), .pilot_en(pilot_en), .overflow_clr(overflow_clr),
    .mpx_o(s_mpx), .mpx_valid(s_valid), .overflow(s_ovf));
  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mpx_valid) begin
        if (q.size() == 0) chk("unexpected_mpx_valid", 1, 0);
        else begin
          e = q.pop_front();
          if (e.cm) begin
            chk("mpx_o", int'(mpx_o), e.em);
            chk("overflow", int'(overflow), 0);
          end
          if (e.cs) begin
            chk("sat_mpx_o", int'(s_mpx), e.es);
            chk("sat_overflow", int'(s_ovf), int'(e.eos));
          end
        end
      end
    end
  end
  task automatic tick(input bit ce, input bit av, input bit cm, input int em,
                      input bit cs, input int es, input bit eos);
    clken = ce;
    audio_valid = av;
    @(posedge clk);
    if (ce) begin
      if (fill < 3) fill++;
      if (fill == 3) q.push_back('{cm, em, cs, es, eos});
    end
    #1;
    clken = 0;
    audio_valid = 0;
  endtask
  task automatic load(input int l, input int r, input bit se, input bit pe);
    audio_l = 16'(l);
    audio_r = 16'(r);
    stereo_en = se;
    pilot_en = pe;
    tick(0, 1, 0, 0, 0, 0, 0);
  endtask
  task automatic run(input int n, input int em, input int es, input bit eos);
    for (int i = 0; i < n; i++) tick(1, 0, i >= 2, em, i >= 2, es, eos);
  endtask
  initial begin
    logic signed [15:0] rec, srec;
    #23;
    chk("reset_mpx_o", int'(mpx_o), 0);
    chk("reset_mpx_valid", int'(mpx_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_sat_overflow", int'(s_ovf), 0);
    @(negedge clk);
    reset_n = 1;
    load(16384, 16384, 0, 0);
    run(6, 8192, 32767, 1);
    audio_l = 0;
    audio_r = 0;
    tick(1, 1, 1, 8192, 1, 32767, 1);
    tick(1, 0, 1, 8192, 1, 32767, 1);
    tick(1, 0, 1, 8192, 1, 32767, 1);
    tick(1, 0, 1, 0, 1, 0, 1);
    tick(1, 0, 1, 0, 1, 0, 1);
    overflow_clr = 1;
    tick(0, 0, 0, 0, 0, 0, 0);
    overflow_clr = 0;
    run(3, 0, 0, 0);
    fsin2x_i = 511;
    load(16384, -16384, 1, 0);
    run(5, 8176, 32704, 0);
    fsin_i = -512;
    load(0, 0, 1, 1);
    run(5, -2048, -2048, 0);
    load(0, 0, 0, 1);
    run(5, 0, 0, 0);
    load(32767, 32767, 0, 0);
    run(5, 16383, 32767, 1);
    overflow_clr = 1;
    run(4, 16383, 32767, 1);
    overflow_clr = 0;
    load(-32768, -32768, 0, 0);
    run(5, -16384, -32768, 1);
    load(0, 0, 0, 0);
    run(4, 0, 0, 1);
    rec = mpx_o;
    srec = s_mpx;
    for (int i = 0; i < 10; i++) begin
      audio_l = (i == 9) ? 16'sd8192 : 16'(i * 1000);
      audio_r = audio_l;
      tick(0, i % 2 == 1, 0, 0, 0, 0, 0);
    end
    chk("gap_mpx_stable", int'(mpx_o), int'(rec));
    chk("gap_sat_stable", int'(s_mpx), int'(srec));
    run(4, 4096, 16384, 1);
    @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    chk("midreset_mpx_o", int'(mpx_o), 0);
    chk("midreset_mpx_valid", int'(mpx_valid), 0);
    chk("midreset_sat_overflow", int'(s_ovf), 0);
    fill = 0;
    @(negedge clk);
    reset_n = 1;
    load(0, 0, 1, 1);
    run(5, -2048, -2048, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stereo_mpx_mod.md
STEREO_MPX_MOD -- requirements
Module: stereo_mpx_mod

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 10: width of the signed NCO sine inputs.
REQ-002 SHALL have parameter AUDIO_WIDTH, default 16: width of the signed L/R audio samples.
REQ-003 SHALL have parameter MPX_WIDTH, default 16: width of the signed composite output.
REQ-004 SHALL have parameter AUDIO_SHIFT, default 2: right shift applied to the mono+stereo sum.
REQ-005 SHALL have parameter PILOT_SHIFT, default 4: pilot attenuation; MPX_WIDTH-OUT_WIDTH-PILOT_SHIFT SHALL be >= 0.
REQ-006 clk  in  1  single clock; all state on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 clken  in  1  composite sample-rate enable; NCO rate.
REQ-009 audio_valid  in  1  one-cycle strobe; audio_l/audio_r are valid.
REQ-010 audio_l  in  AUDIO_WIDTH  signed left sample.
REQ-011 audio_r  in  AUDIO_WIDTH  signed right sample.
REQ-012 fsin_i  in  OUT_WIDTH  signed pilot sine from NCO (fsin_o).
REQ-013 fsin2x_i  in  OUT_WIDTH  signed subcarrier sine from NCO (fsin2x_o).
REQ-014 stereo_en  in  1  1 = stereo subcarrier on; 0 = mono, no subcarrier, no pilot.
REQ-015 pilot_en  in  1  pilot on (effective only when stereo_en=1).
REQ-016 overflow_clr  in  1  clears sticky overflow.
REQ-017 mpx_o  out  MPX_WIDTH  signed composite MPX sample.
REQ-018 mpx_valid  out  1  one-cycle strobe on each new mpx_o.
REQ-019 overflow  out  1  sticky saturation flag.

Function
REQ-020 Audio hold: on any clk with audio_valid=1 (independent of clken), l_q<=audio_l, r_q<=audio_r; otherwise hold.
REQ-021 Stage 1 (clken=1): m1<=l_q+r_q, s1<=l_q-r_q (AUDIO_WIDTH+1, signed, no loss); c1<=stereo_en?fsin2x_i:0; p1<=(stereo_en&pilot_en)?fsin_i:0.
REQ-022 Stage 2 (clken=1): prod2<=s1*c1 (full AUDIO_WIDTH+1+OUT_WIDTH signed); m2<=m1; p2<=p1.
REQ-023 Stage 3 (clken=1): sum=(((m2<<<(OUT_WIDTH-1))+prod2)>>>(OUT_WIDTH-1+AUDIO_SHIFT)) + (p2<<<(MPX_WIDTH-OUT_WIDTH-PILOT_SHIFT)); arithmetic shifts (floor), internal width wide enough that sum never wraps.
REQ-024 Stage 3: mpx_o<=sum clamped to [-2^(MPX_WIDTH-1), 2^(MPX_WIDTH-1)-1].
REQ-025 Clamp event sets overflow<=1; overflow_clr=1 clears it; simultaneous clamp and clear: set wins.
REQ-026 clken=0: all pipeline registers and mpx_o hold; mpx_valid=0.
REQ-027 Latency: NCO/held-audio values sampled on clken N appear on mpx_o after clken N+2 (three enabled edges).
REQ-028 Fill counter (2 bits, saturating at 3) increments on each clken; mpx_valid<=1 for one clk after a clken edge at which the counter already equals 3 or reaches it at that edge's stage-3 update, i.e. first mpx_valid follows the 3rd clken after reset.
REQ-029 audio_valid coincident with clken: stage 1 uses the previously held l_q/r_q; new sample enters on the next clken.
REQ-030 stereo_en/pilot_en changes take effect at the next stage-1 update; no pipeline flush.

Reset
REQ-031 reset_n=0 asynchronously clears l_q, r_q, all stage registers, fill counter, mpx_o=0, mpx_valid=0, overflow=0.
REQ-032 Reset mid-operation discards the pipeline; after release, first mpx_valid follows the 3rd clken again.

Verification
REQ-033 Reset, then clken every cycle: mpx_valid=0 for the first two clken edges and rises after the 3rd; mpx_o=0 and overflow=0 throughout reset.
REQ-034 Mono: stereo_en=0, L=R=16384 -> mpx_o=8192 steady, overflow=0.
REQ-035 Stereo: stereo_en=1, pilot_en=0, L=16384, R=-16384, fsin2x_i=511 -> mpx_o=8176.
REQ-036 Pilot: L=R=0, stereo_en=pilot_en=1, fsin_i=-512 -> mpx_o=-2048; with stereo_en=0 -> mpx_o=0.
REQ-037 Saturation (AUDIO_SHIFT=0): L=R=32767, stereo_en=0 -> mpx_o=32767, overflow=1; overflow_clr held while still clamping -> overflow remains 1.
REQ-038 clken low for 10 cycles with audio_valid pulses -> mpx_o stable, mpx_valid=0; next clken uses the latest held sample.
